mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single 64-bit memory port between instruction fetch and the load/store unit.
- The fetch requester is the prefetch queue; the data requester is the LSU.
- Issues one bus command per cycle, tracks outstanding transactions by memory tag, and routes each tagged response back to its owner.
- Drives mem_bus_none, which the prefetch queue uses as its fetch-data-valid qualifier; drops responses for fetches squashed by a branch redirect.

Parameters:
- NUM_TAGS, 15: distinct nonzero memory tags; sizes the outstanding table.
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits before fetch is forced.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  branch redirect (take_branch); squash all outstanding fetches
- if_req_valid  in  1  fetch request pending
- if_req_addr  in  XLEN  8-byte-aligned fetch address
- if_req_ready  out  1  fetch accepted by memory this cycle
- if_resp_valid  out  1  fetch data returned
- if_resp_data  out  64  fetch data
- dc_req_valid  in  1  data request pending
- dc_req_cmd  in  2  BUS_LOAD or BUS_STORE
- dc_req_addr  in  XLEN  data address
- dc_req_data  in  64  store data
- dc_req_ready  out  1  data request accepted this cycle
- dc_resp_valid  out  1  load data returned
- dc_resp_data  out  64  load data
- proc2mem_command  out  2  BUS_NONE/BUS_LOAD/BUS_STORE
- proc2mem_addr  out  XLEN  bus address
- proc2mem_data  out  64  bus store data
- mem2proc_response  in  4  tag assigned to this cycle's command; 0 = rejected
- mem2proc_data  in  64  returned data
- mem2proc_tag  in  4  tag of returned data; 0 = none
- mem_bus_none  out  1  data side not using the bus this cycle

Behaviour:
- Issue path is combinational:
  - Grant selects the command, address and data.
  - ready = grant & (mem2proc_response != 0).
  - A requester not made ready holds its request unchanged; it retries the next cycle.
- Priority:
  - Data wins by default.
  - starve_cnt increments each cycle dc is granted while if_req_valid is high.
  - When starve_cnt == STARVE_LIMIT, fetch is granted and starve_cnt clears.
  - starve_cnt also clears whenever fetch is granted or if_req_valid is low.
- mem_bus_none = !(dc_req_valid & dc granted).
- Outstanding table: NUM_TAGS entries indexed by tag, each holding {valid, owner(IF/DC), squashed}.
  - An accepted load or fetch allocates entry[mem2proc_response].
  - Stores never allocate; they complete on acceptance.
- Table full (NUM_TAGS valid entries):
  - No load or fetch is granted; command is BUS_NONE unless a store is pending.
  - Both readies stay low for non-store requests.
- Completion: mem2proc_tag != 0 with entry valid:
  - owner DC: dc_resp_valid = 1 with mem2proc_data.
  - owner IF and not squashed: if_resp_valid = 1 with mem2proc_data.
  - Squashed IF: data dropped.
  - In all cases the entry is cleared.
- Tag for an invalid entry: ignored, with no response and no state change.
- Same tag completes and re-allocates in one cycle: completion is processed first, then allocation; the entry ends valid with the new owner.
- flush:
  - Sets squashed on every valid IF entry, including one allocated that cycle.
  - Forces if_resp_valid low that cycle.
  - Leaves DC entries untouched.
- Response latency: same cycle as mem2proc_tag (combinational pass-through); no added pipeline stage.
- Reset (any time, including mid-transaction):
  - All entries invalid; starve_cnt = 0.
  - Outputs: command BUS_NONE, both readies 0, both resp_valid 0, mem_bus_none 1.
  - Responses arriving after reset are dropped.
- No zero-tag allocation; a response value of 0 is never stored.

Decomposition:
- Shared package mem_arb_pkg:
  - BUS_COMMAND enum (BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2).
  - MEM_TAG_W=4.
  - REQ_OWNER enum (OWNER_IF, OWNER_DC).
  - MEM_TAG_ENTRY packed struct {valid, owner, squashed}.
- Sub-module mem_tag_table:
  - Holds the entry array, full flag, allocate/complete/squash ports and owner lookup.
  - The arbiter keeps the priority and starvation logic.

Test Plan:
- Fetch only, addr 0x100, memory responds tag 3 → if_req_ready=1, proc2mem_command=BUS_LOAD, mem_bus_none=1; tag 3 returns 0xDEADBEEF_00000013 → if_resp_valid=1 with that data.
- Both requesters valid, data tag 5 accepted → dc_req_ready=1, if_req_ready=0, mem_bus_none=0; after 4 consecutive data grants the 5th grant goes to fetch.
- Fetch accepted with tag 7, flush next cycle, tag 7 returns → if_resp_valid stays 0 and entry 7 is freed (re-allocatable).
- mem2proc_response=0 for dc load at 0x2000 → dc_req_ready=0, request held; next cycle response 2 → accepted, then load data routed to dc_resp.
- Fill all 15 tags with loads → 16th load ready=0 while a store is still accepted; returning tag 1 frees a slot and the load issues the next cycle.
- Reset asserted with 3 outstanding tags, then those tags return → no resp_valid; all outputs at reset values.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory bus arbiter.
// Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

    localparam int MEM_TAG_W = 4;
    localparam int XLEN      = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DC = 1'b1
    } REQ_OWNER;

    typedef struct packed {
        logic     valid;
        REQ_OWNER owner;
        logic     squashed;
    } MEM_TAG_ENTRY;

endpackage
`default_nettype wire

// File: rtl/mem_tag_table.sv
`default_nettype none
// ============================================================================
// Module      : mem_tag_table
// Description : Outstanding-transaction table indexed by memory tag.
// Revision    : 1.0
// ============================================================================
module mem_tag_table
    import mem_arb_pkg::*;
#(
    parameter int NUM_TAGS = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_valid_i,
    input  logic [MEM_TAG_W-1:0] alloc_tag_i,
    input  REQ_OWNER             alloc_owner_i,
    input  logic                 cmpl_valid_i,
    input  logic [MEM_TAG_W-1:0] cmpl_tag_i,
    input  logic                 squash_i,
    output logic                 full_o,
    output MEM_TAG_ENTRY         lookup_o
);

    MEM_TAG_ENTRY entry_q [1:NUM_TAGS];
    MEM_TAG_ENTRY entry_d [1:NUM_TAGS];
    logic [MEM_TAG_W:0] w_count;

    always_comb begin
        lookup_o = '0;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            if (cmpl_valid_i && (cmpl_tag_i == MEM_TAG_W'(i))) begin
                lookup_o = entry_q[i];
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            w_count = w_count + (MEM_TAG_W+1)'(entry_q[i].valid);
        end
    end

    assign full_o = (w_count == (MEM_TAG_W+1)'(NUM_TAGS));

    // Completion frees the slot before allocation so a reused tag ends owned
    // by the new requester; squash runs last to catch same-cycle fetches.
    always_comb begin
        for (int i = 1; i <= NUM_TAGS; i++) begin
            entry_d[i] = entry_q[i];
            if (cmpl_valid_i && (cmpl_tag_i == MEM_TAG_W'(i))) begin
                entry_d[i] = '0;
            end
            if (alloc_valid_i && (alloc_tag_i == MEM_TAG_W'(i))) begin
                entry_d[i].valid    = 1'b1;
                entry_d[i].owner    = alloc_owner_i;
                entry_d[i].squashed = 1'b0;
            end
            if (squash_i && entry_d[i].valid && (entry_d[i].owner == OWNER_IF)) begin
                entry_d[i].squashed = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i <= NUM_TAGS; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares the memory port between fetch and LSU, routes tagged data.
// Revision    : 1.0
// ============================================================================
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_TAGS     = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 if_req_valid,
    input  logic [XLEN-1:0]      if_req_addr,
    output logic                 if_req_ready,
    output logic                 if_resp_valid,
    output logic [63:0]          if_resp_data,
    input  logic                 dc_req_valid,
    input  logic [1:0]           dc_req_cmd,
    input  logic [XLEN-1:0]      dc_req_addr,
    input  logic [63:0]          dc_req_data,
    output logic                 dc_req_ready,
    output logic                 dc_resp_valid,
    output logic [63:0]          dc_resp_data,
    output logic [1:0]           proc2mem_command,
    output logic [XLEN-1:0]      proc2mem_addr,
    output logic [63:0]          proc2mem_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_response,
    input  logic [63:0]          mem2proc_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag,
    output logic                 mem_bus_none
);

    localparam int                    c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    logic [c_STARVE_W-1:0] starve_q;
    logic [c_STARVE_W-1:0] starve_d;

    logic         w_full;
    logic         w_dc_is_load;
    logic         w_dc_is_store;
    logic         w_dc_elig;
    logic         w_if_elig;
    logic         w_if_grant;
    logic         w_dc_grant;
    logic         w_accept;
    logic         w_alloc;
    logic         w_hit;
    REQ_OWNER     w_alloc_owner;
    MEM_TAG_ENTRY w_lookup;

    assign w_dc_is_load  = (dc_req_cmd == BUS_LOAD);
    assign w_dc_is_store = (dc_req_cmd == BUS_STORE);

    // Stores never occupy a tag, so a full table only blocks tag-consuming reads.
    assign w_dc_elig = dc_req_valid && (w_dc_is_store || (w_dc_is_load && !w_full));
    assign w_if_elig = if_req_valid && !w_full;

    assign w_if_grant = !reset && w_if_elig && (!w_dc_elig || (starve_q == c_STARVE_MAX));
    assign w_dc_grant = !reset && w_dc_elig && !w_if_grant;

    assign w_accept     = (mem2proc_response != '0);
    assign if_req_ready = w_if_grant && w_accept;
    assign dc_req_ready = w_dc_grant && w_accept;
    assign mem_bus_none = !(dc_req_valid && w_dc_grant);

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (w_if_grant) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = if_req_addr;
        end else if (w_dc_grant) begin
            proc2mem_command = dc_req_cmd;
            proc2mem_addr    = dc_req_addr;
            proc2mem_data    = dc_req_data;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req_valid || w_if_grant) begin
            starve_d = '0;
        end else if (w_dc_grant && (starve_q != c_STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign w_alloc       = if_req_ready || (dc_req_ready && w_dc_is_load);
    assign w_alloc_owner = if_req_ready ? OWNER_IF : OWNER_DC;

    mem_tag_table #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tag_table (
        .clock         (clock),
        .reset         (reset),
        .alloc_valid_i (w_alloc),
        .alloc_tag_i   (mem2proc_response),
        .alloc_owner_i (w_alloc_owner),
        .cmpl_valid_i  (mem2proc_tag != '0),
        .cmpl_tag_i    (mem2proc_tag),
        .squash_i      (flush),
        .full_o        (w_full),
        .lookup_o      (w_lookup)
    );

    assign w_hit         = !reset && w_lookup.valid;
    assign dc_resp_valid = w_hit && (w_lookup.owner == OWNER_DC);
    assign if_resp_valid = w_hit && (w_lookup.owner == OWNER_IF) && !w_lookup.squashed && !flush;
    assign dc_resp_data  = mem2proc_data;
    assign if_resp_data  = mem2proc_data;

endmodule
`default_nettype wire
